// File: rtl/mux_pipe_reg_if.sv
// Handshake bus for mux_pipe_reg: input words + select upstream, registered word + error status downstream.
interface mux_pipe_reg_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned SEL_W  = 3
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        select;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;
  logic [SEL_W-1:0]        err_sel;
  logic                    err_clr;

  modport master (
    output in_bus, select, in_valid, out_ready, err_clr,
    input  in_ready, out, out_valid, err, err_sel
  );

  modport slave (
    input  in_bus, select, in_valid, out_ready, err_clr,
    output in_ready, out, out_valid, err, err_sel
  );
endinterface

// File: rtl/mux_pipe_reg.sv
// Registered N-input word mux with valid/ready handshake, two-entry skid buffer
// and sticky out-of-range select detection.
module mux_pipe_reg #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned SEL_W  = 3
) (
  input  logic           clk,
  input  logic           reset,
  mux_pipe_reg_if.slave  bus
);
  localparam int unsigned CMP_W = SEL_W + 1;

  logic [WIDTH-1:0] o_data, o_data_nxt, s_data, s_data_nxt, word_c;
  logic             o_valid, o_valid_nxt, s_valid, s_valid_nxt;
  logic             in_ready_q, in_ready_nxt;
  logic             err_q, err_nxt;
  logic [SEL_W-1:0] err_sel_q, err_sel_nxt;
  logic             accept_c, legal_c;

  assign accept_c = bus.in_valid && in_ready_q;
  // Extra bit so NUM_IN == 2**SEL_W compares correctly
  assign legal_c  = CMP_W'(bus.select) < CMP_W'(NUM_IN);

  // Pick only the selected word; illegal codes yield zero and are discarded anyway
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.select == SEL_W'(k)) word_c = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_data_nxt  = o_data;
    o_valid_nxt = o_valid;
    s_data_nxt  = s_data;
    s_valid_nxt = s_valid;
    err_nxt     = err_q;
    err_sel_nxt = err_sel_q;

    if (o_valid && bus.out_ready) o_valid_nxt = 1'b0;

    // S full implies in_ready low, so no accept can race the S->O move
    if (s_valid) begin
      if (bus.out_ready) begin
        o_data_nxt  = s_data;
        o_valid_nxt = 1'b1;
        s_valid_nxt = 1'b0;
      end
    end else if (accept_c && legal_c) begin
      if (!o_valid || bus.out_ready) begin
        o_data_nxt  = word_c;
        o_valid_nxt = 1'b1;
      end else begin
        s_data_nxt  = word_c;
        s_valid_nxt = 1'b1;
      end
    end

    if (bus.err_clr) begin
      err_nxt     = 1'b0;
      err_sel_nxt = '0;
    end
    // A new error beats a simultaneous clear; otherwise the first error is held
    if (accept_c && !legal_c) begin
      err_nxt = 1'b1;
      if (!err_q || bus.err_clr) err_sel_nxt = bus.select;
    end

    in_ready_nxt = !s_valid_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      s_data     <= '0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
      err_sel_q  <= '0;
    end else begin
      o_data     <= o_data_nxt;
      o_valid    <= o_valid_nxt;
      s_data     <= s_data_nxt;
      s_valid    <= s_valid_nxt;
      in_ready_q <= in_ready_nxt;
      err_q      <= err_nxt;
      err_sel_q  <= err_sel_nxt;
    end
  end

  assign bus.out       = o_data;
  assign bus.out_valid = o_valid;
  assign bus.in_ready  = in_ready_q;
  assign bus.err       = err_q;
  assign bus.err_sel   = err_sel_q;
endmodule

// File: doc/mux_pipe_reg.md
# mux_pipe_reg

Parametrised, registered N-input word multiplexer with a valid/ready handshake on both sides, a two-entry skid buffer for full throughput, and sticky out-of-range select detection. It replaces fixed-width combinational operand/result selectors in the 16-bit datapath where the selected word must cross a pipeline stage boundary. Illegal select codes are consumed and flagged rather than silently producing X.

## Interface

Parameters:
- WIDTH, 16: data word width in bits.
- NUM_IN, 6: number of input words; must satisfy 2 ≤ NUM_IN ≤ 2^SEL_W.
- SEL_W, 3: select field width.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  flattened inputs; word k at bits [k*WIDTH +: WIDTH].
- select  input  SEL_W  index of the word to forward; qualified by in_valid.
- in_valid  input  1  upstream presents in_bus/select.
- in_ready  output  1  block can accept this cycle.
- out  output  WIDTH  selected word, registered.
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  downstream consumes out this cycle.
- err  output  1  sticky: an accepted transaction had select ≥ NUM_IN.
- err_sel  output  SEL_W  select value of the first bad transaction since the last clear.
- err_clr  input  1  synchronous clear of err/err_sel.

## Operation

- Storage: output register O (data + valid) and skid register S (data + valid). Only the selected word is stored, never the whole bus.
- Accept: in_valid && in_ready. in_ready = !S.valid, driven from a flop (no combinational path from out_ready).
- Legal accept (select < NUM_IN), word w = in_bus[select]:
  - O empty, or O valid and out_ready: w → O.
  - Otherwise: w → S.
- Drain: O valid and out_ready → O empties, unless S is valid (S → O, S empties) or a legal accept lands in O the same cycle.
- S valid and O valid with out_ready low: hold both; in_ready low.
- Illegal accept (select ≥ NUM_IN): handshake completes (upstream is not stalled), word is discarded, O/S unchanged, err ← 1; err_sel ← select only if err was 0 (first error is held).
- err_clr: err ← 0, err_sel ← 0. If err_clr and an illegal accept occur in the same cycle, the error wins: err = 1, err_sel = new select.
- Ordering: words leave in acceptance order; S is always older than any new input.
- No $display or X assignment in synthesis paths; every case arm is assigned.

## Timing

- Reset (async assert, sync deassert by the system): O.valid = 0, S.valid = 0, out = 0, out_valid = 0, in_ready = 1, err = 0, err_sel = 0. A transaction in flight at reset is lost.
- Latency: legal accept in cycle t → out_valid = 1 with the word in cycle t+1.
- Throughput: one word per cycle while out_ready is held high; in_ready stays 1.
- Backpressure: with out_ready low, the block absorbs two words (O, then S). in_ready drops in the cycle after S fills, and rises the cycle after S drains.
- out and out_valid are stable while out_valid && !out_ready.
- err rises in the cycle after the illegal accept.
- select and in_bus are sampled only on an accept edge.

## Test plan

- Reset/idle: assert reset mid-stream with O and S full → out_valid = 0, in_ready = 1, err = 0 immediately (asynchronous), out = 0.
- Streaming: WIDTH = 16, NUM_IN = 6, in_bus words k = 16'hA000+k, select 0..5 on consecutive cycles, out_ready = 1 → out = A000..A005 on cycles t+1..t+6, no bubbles.
- Backpressure: out_ready = 0; send select 2 then 4 → O = A002, S = A004, in_ready = 0. Release out_ready → A002 then A004 on consecutive cycles; in_ready returns to 1.
- Illegal select: send select 6 then 7 → both accepted, no out_valid, err = 1, err_sel = 6 (not 7). Next, a legal select 1 → A001 delivered normally.
- Clear collision: err = 1 and err_sel = 6; assert err_clr in the same cycle as an accept with select 7 → err = 1, err_sel = 7. err_clr alone on the next cycle → err = 0, err_sel = 0.
- Parameter sweep: WIDTH = 8, NUM_IN = 4, SEL_W = 2, random valid/ready → scoreboard shows in-order, lossless delivery with no false err.
